// File: rtl/a2d_sched.sv
`default_nettype none
// ============================================================================
//  Module   : a2d_sched
//  Purpose  : Round-robin A2D conversion scheduler. Starts one conversion every
//             PERIOD clocks, stores each result per slot, and flags timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module a2d_sched #(
    parameter int PERIOD  = 4096,
    parameter int TIMEOUT = 512
) (
    input  logic        clk,
    input  logic        RST_n,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        strt_cnv,
    output logic [2:0]  chnl,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic [3:0]  upd,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_START = 2'd1,
        ST_CONV  = 2'd2
    } state_t;

    localparam logic [15:0] PER_LAST = 16'(PERIOD - 1);
    localparam logic [9:0]  TMO_LAST = 10'(TIMEOUT - 1);

    state_t      state_q,   state_d;
    logic [1:0]  slot_q,    slot_d;
    logic [15:0] per_cnt_q, per_cnt_d;
    logic [9:0]  tmo_cnt_q, tmo_cnt_d;
    logic        pend_q,    pend_d;
    logic        strt_q,    strt_d;
    logic [2:0]  chnl_q,    chnl_d;
    logic [11:0] batt_q,    batt_d;
    logic [11:0] curr_q,    curr_d;
    logic [11:0] brake_q,   brake_d;
    logic [11:0] torque_q,  torque_d;
    logic [3:0]  upd_q,     upd_d;
    logic        err_q,     err_d;

    logic        w_per_exp;
    logic        w_tmo_exp;
    logic [1:0]  w_slot_nxt;

    // Slot-to-channel map: channel 2 is not sampled by this scheduler.
    function automatic logic [2:0] slot_chnl(input logic [1:0] s);
        case (s)
            2'd0:    slot_chnl = 3'd0;
            2'd1:    slot_chnl = 3'd1;
            2'd2:    slot_chnl = 3'd3;
            default: slot_chnl = 3'd4;
        endcase
    endfunction

    assign w_per_exp  = (per_cnt_q == PER_LAST);
    assign w_tmo_exp  = (state_q == ST_CONV) && (tmo_cnt_q == TMO_LAST);
    assign w_slot_nxt = slot_q + 2'd1;

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        per_cnt_d = w_per_exp ? 16'd0 : per_cnt_q + 16'd1;
        tmo_cnt_d = tmo_cnt_q;
        pend_d    = pend_q;
        strt_d    = 1'b0;
        chnl_d    = chnl_q;
        batt_d    = batt_q;
        curr_d    = curr_q;
        brake_d   = brake_q;
        torque_d  = torque_q;
        upd_d     = 4'b0000;
        err_d     = err_q;

        case (state_q)
            ST_WAIT: begin
                if (w_per_exp) begin
                    state_d = ST_START;
                    strt_d  = 1'b1;
                    chnl_d  = slot_chnl(slot_q);
                    pend_d  = 1'b0;
                end
            end

            ST_START: begin
                state_d   = ST_CONV;
                tmo_cnt_d = 10'd0;
                if (w_per_exp) begin
                    pend_d = 1'b1;
                end
            end

            ST_CONV: begin
                tmo_cnt_d = tmo_cnt_q + 10'd1;
                if (w_per_exp) begin
                    pend_d = 1'b1;
                end
                // Completion takes priority over a coincident timeout.
                if (cnv_cmplt || w_tmo_exp) begin
                    if (cnv_cmplt) begin
                        upd_d[slot_q] = 1'b1;
                        case (slot_q)
                            2'd0:    batt_d   = res;
                            2'd1:    curr_d   = res;
                            2'd2:    brake_d  = res;
                            default: torque_d = res;
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                    slot_d = w_slot_nxt;
                    // A period that elapsed mid-conversion restarts immediately.
                    if (pend_q || w_per_exp) begin
                        state_d = ST_START;
                        strt_d  = 1'b1;
                        chnl_d  = slot_chnl(w_slot_nxt);
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end

            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= ST_WAIT;
            slot_q    <= 2'd0;
            per_cnt_q <= 16'd0;
            tmo_cnt_q <= 10'd0;
            pend_q    <= 1'b0;
            strt_q    <= 1'b0;
            chnl_q    <= 3'd0;
            batt_q    <= 12'h000;
            curr_q    <= 12'h000;
            brake_q   <= 12'h000;
            torque_q  <= 12'h000;
            upd_q     <= 4'b0000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            per_cnt_q <= per_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            pend_q    <= pend_d;
            strt_q    <= strt_d;
            chnl_q    <= chnl_d;
            batt_q    <= batt_d;
            curr_q    <= curr_d;
            brake_q   <= brake_d;
            torque_q  <= torque_d;
            upd_q     <= upd_d;
            err_q     <= err_d;
        end
    end

    assign strt_cnv = strt_q;
    assign chnl     = chnl_q;
    assign batt     = batt_q;
    assign curr     = curr_q;
    assign brake    = brake_q;
    assign torque   = torque_q;
    assign upd      = upd_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_a2d_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_a2d_sched
//  Purpose  : Directed self-checking bench for a2d_sched; instance A runs
//             PERIOD=16, instance B runs PERIOD=64 (both TIMEOUT=512).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_a2d_sched;

    logic        clk = 1'b0;
    always #10 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic        rst_n_a = 1'b0, cmplt_a = 1'b0;
    logic [11:0] res_a = 12'h000;
    logic        strt_a, err_a;
    logic [2:0]  chnl_a;
    logic [11:0] batt_a, curr_a, brake_a, torque_a;
    logic [3:0]  upd_a;

    logic        rst_n_b = 1'b0, cmplt_b = 1'b0;
    logic [11:0] res_b = 12'h000;
    logic        strt_b, err_b;
    logic [2:0]  chnl_b;
    logic [11:0] batt_b, curr_b, brake_b, torque_b;
    logic [3:0]  upd_b;

    a2d_sched #(.PERIOD(16), .TIMEOUT(512)) u_dut_a (
        .clk(clk), .RST_n(rst_n_a), .cnv_cmplt(cmplt_a), .res(res_a),
        .strt_cnv(strt_a), .chnl(chnl_a), .batt(batt_a), .curr(curr_a),
        .brake(brake_a), .torque(torque_a), .upd(upd_a), .err(err_a)
    );

    a2d_sched #(.PERIOD(64), .TIMEOUT(512)) u_dut_b (
        .clk(clk), .RST_n(rst_n_b), .cnv_cmplt(cmplt_b), .res(res_b),
        .strt_cnv(strt_b), .chnl(chnl_b), .batt(batt_b), .curr(curr_b),
        .brake(brake_b), .torque(torque_b), .upd(upd_b), .err(err_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic strt_of(input int w);
        return (w == 0) ? strt_a : strt_b;
    endfunction

    function automatic logic [11:0] reg_a(input int slot);
        case (slot)
            0:       return batt_a;
            1:       return curr_a;
            2:       return brake_a;
            default: return torque_a;
        endcase
    endfunction

    // Advance negedge by negedge until the chosen instance shows strt_cnv.
    task automatic wait_strt(input int w, input int limit, input string tag);
        int n = 0;
        while (strt_of(w) !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (strt_of(w) !== 1'b1) chk(tag, 64'(strt_of(w)), 64'd1);
    endtask

    int t0, t_start, t_rel;
    logic [2:0] exp_chnl [5] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd0};
    logic [3:0] exp_upd  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        // ---------------- instance A: PERIOD=16 ----------------
        repeat (3) @(negedge clk);
        chk("a_rst_ctl",  {strt_a, chnl_a, upd_a, err_a}, 64'd0);
        chk("a_rst_regs", {batt_a, curr_a, brake_a, torque_a}, 64'd0);
        rst_n_a = 1'b1;
        t0 = cyc_cnt;
        wait_strt(0, 100, "a_first_strt_timeout");
        chk("a_first_strt_dly", 64'(cyc_cnt - t0), 64'd16);
        t_start = cyc_cnt;

        // 20-cycle engine latency: every period overruns, so starts follow completions directly.
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("a_chnl_%0d", i), 64'(chnl_a), 64'(exp_chnl[i]));
            repeat (20) @(negedge clk);
            cmplt_a = 1'b1;
            res_a   = 12'hA5C;
            @(negedge clk);
            cmplt_a = 1'b0;
            chk($sformatf("a_upd_%0d", i), 64'(upd_a), 64'(exp_upd[i]));
            chk($sformatf("a_reg_%0d", i), 64'(reg_a(i % 4)), 64'h A5C);
            chk($sformatf("a_restart_%0d", i), 64'(strt_a), 64'd1);
            chk($sformatf("a_spacing_%0d", i), 64'(cyc_cnt - t_start), 64'd21);
            t_start = cyc_cnt;
        end
        chk("a_regs_all", {batt_a, curr_a, brake_a, torque_a}, {16'd0, 48'hA5C_A5C_A5C_A5C});
        chk("a_chnl_slot1", 64'(chnl_a), 64'd1);

        // Completion on the exact timeout cycle must win.
        repeat (512) @(negedge clk);
        cmplt_a = 1'b1;
        res_a   = 12'hFFF;
        @(negedge clk);
        cmplt_a = 1'b0;
        chk("a_edge_curr", 64'(curr_a), 64'hFFF);
        chk("a_edge_upd",  64'(upd_a),  64'b0010);
        chk("a_edge_err",  64'(err_a),  64'd0);

        // ---------------- instance B: PERIOD=64 ----------------
        rst_n_b = 1'b1;
        t0 = cyc_cnt;
        wait_strt(1, 200, "b_first_strt_timeout");
        chk("b_first_strt_dly", 64'(cyc_cnt - t0), 64'd64);
        chk("b_first_chnl", 64'(chnl_b), 64'd0);
        t_start = cyc_cnt;
        repeat (10) @(negedge clk);
        cmplt_b = 1'b1;
        res_b   = 12'h123;
        @(negedge clk);
        cmplt_b = 1'b0;
        chk("b_upd_batt", 64'(upd_b), 64'b0001);
        chk("b_regs_1st", {batt_b, curr_b, brake_b, torque_b}, {16'd0, 48'h123_000_000_000});
        chk("b_strt_low", 64'(strt_b), 64'd0);

        // Stray completion while idle.
        @(negedge clk);
        cmplt_b = 1'b1;
        res_b   = 12'h777;
        @(negedge clk);
        cmplt_b = 1'b0;
        chk("b_stray_upd",  64'(upd_b), 64'd0);
        chk("b_stray_regs", {batt_b, curr_b, brake_b, torque_b}, {16'd0, 48'h123_000_000_000});

        wait_strt(1, 200, "b_second_strt_timeout");
        chk("b_spacing", 64'(cyc_cnt - t_start), 64'd64);
        chk("b_chnl_slot1", 64'(chnl_b), 64'd1);

        // No completion on slot 1: timeout counter hits 511 in the 512th cycle after strt_cnv.
        repeat (512) @(negedge clk);
        chk("b_err_before", 64'(err_b), 64'd0);
        @(negedge clk);
        chk("b_err_set",    64'(err_b), 64'd1);
        chk("b_tmo_curr",   64'(curr_b), 64'd0);
        chk("b_tmo_upd",    64'(upd_b),  64'd0);
        chk("b_tmo_next",   {strt_b, chnl_b}, {60'd0, 1'b1, 3'd3});

        // Reset in the middle of a conversion, then a late completion.
        repeat (3) @(negedge clk);
        rst_n_b = 1'b0;
        #1;
        chk("b_arst_ctl",  {strt_b, chnl_b, upd_b, err_b}, 64'd0);
        chk("b_arst_regs", {batt_b, curr_b, brake_b, torque_b}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n_b = 1'b1;
        t_rel = cyc_cnt;
        repeat (3) @(negedge clk);
        cmplt_b = 1'b1;
        res_b   = 12'h555;
        @(negedge clk);
        cmplt_b = 1'b0;
        chk("b_late_upd",  64'(upd_b), 64'd0);
        chk("b_late_regs", {batt_b, curr_b, brake_b, torque_b}, 64'd0);
        wait_strt(1, 200, "b_post_rst_strt_timeout");
        chk("b_post_rst_dly",  64'(cyc_cnt - t_rel), 64'd64);
        chk("b_post_rst_chnl", 64'(chnl_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
